// File: rtl/axi3_mem_slave_if.sv
// AXI3 read (AR/R) and write (AW/W/B) channel bundles for the memory responder.
interface axi3_rd_if #(parameter int ID_W = 4) ();
  logic            arvalid, arready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            rvalid, rready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;

  modport slave  (input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
                  output arready, rvalid, rid, rdata, rresp, rlast);
  modport master (output arvalid, arid, araddr, arlen, arsize, arburst, rready,
                  input  arready, rvalid, rid, rdata, rresp, rlast);
endinterface

interface axi3_wr_if #(parameter int ID_W = 4) ();
  logic            awvalid, awready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            wvalid, wready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  modport slave  (input  awvalid, awid, awaddr, awlen, awsize, awburst,
                         wvalid, wid, wdata, wstrb, wlast, bready,
                  output awready, wready, bvalid, bid, bresp);
  modport master (output awvalid, awid, awaddr, awlen, awsize, awburst,
                         wvalid, wid, wdata, wstrb, wlast, bready,
                  input  awready, wready, bvalid, bid, bresp);
endinterface

// File: rtl/axi3_mem_slave.sv
// AXI3 responder over a word-addressed memory; independent read/write FSMs,
// one outstanding burst per direction, programmable first-beat read latency.
module axi3_mem_slave #(
  parameter int          DATA_WIDTH = 32,
  parameter int          MEM_DEPTH  = 1024,
  parameter int          RD_DELAY   = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          ID_W       = 4
) (
  input logic        clk,
  input logic        rst,
  axi3_rd_if.slave   axi3_rd_if,
  axi3_wr_if.slave   axi3_wr_if
);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [3:0]      len;
    logic [1:0]      burst;
    logic [2:0]      size;
    logic [3:0]      beat;
  } burst_t;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

  function automatic logic oor_f(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) || ((off >> 2) >= 32'(MEM_DEPTH));
  endfunction

  function automatic logic [AW-1:0] idx_f(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  function automatic logic wrap_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  function automatic logic bad_f(input logic [2:0] size, input logic [1:0] burst,
                                 input logic [3:0] len);
    return (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len));
  endfunction

  // Wrap window is (len+1)*4 bytes, so window-1 is {len,2'b11} for legal lengths.
  // Illegal wrap lengths fall back to incrementing; they are flagged SLVERR anyway.
  function automatic logic [31:0] next_f(input logic [31:0] a, input logic [1:0] burst,
                                         input logic [3:0] len);
    logic [31:0] mask;
    mask = {26'd0, len, 2'b11};
    case (burst)
      2'b00:   return a;
      2'b10:   return wrap_ok(len) ? ((a & ~mask) | ((a + 32'd4) & mask)) : a + 32'd4;
      default: return a + 32'd4;
    endcase
  endfunction

  logic [NB-1:0][7:0] mem_q [MEM_DEPTH];

  rd_state_e        rd_state_q, rd_state_d;
  wr_state_e        wr_state_q, wr_state_d;
  burst_t           rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             err_q, err_d;

  logic            ar_rdy, r_vld, r_last, aw_rdy, w_rdy, b_vld, mem_we;
  logic [ID_W-1:0] r_id, b_id;
  logic [31:0]     r_data;
  logic [1:0]      r_resp, b_resp;
  logic [AW-1:0]   mem_idx;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_d       = rd_q;
    rd_cnt_d   = rd_cnt_q;
    ar_rdy     = 1'b0;
    r_vld      = 1'b0;
    r_id       = '0;
    r_data     = '0;
    r_resp     = 2'b00;
    r_last     = 1'b0;
    unique case (rd_state_q)
      RD_IDLE: begin
        ar_rdy = 1'b1;
        if (axi3_rd_if.arvalid) begin
          rd_d = '{id: axi3_rd_if.arid, addr: axi3_rd_if.araddr, len: axi3_rd_if.arlen,
                   burst: axi3_rd_if.arburst, size: axi3_rd_if.arsize, beat: 4'd0};
          rd_cnt_d   = '0;
          rd_state_d = (RD_DELAY > 0) ? RD_WAIT : RD_DATA;
        end
      end
      RD_WAIT: begin
        rd_cnt_d = rd_cnt_q + 16'd1;
        if (rd_cnt_q == 16'(RD_DELAY - 1)) rd_state_d = RD_DATA;
      end
      RD_DATA: begin
        r_vld  = 1'b1;
        r_id   = rd_q.id;
        r_data = oor_f(rd_q.addr) ? 32'h0 : mem_q[idx_f(rd_q.addr)];
        r_resp = (oor_f(rd_q.addr) || bad_f(rd_q.size, rd_q.burst, rd_q.len)) ? 2'b10 : 2'b00;
        r_last = (rd_q.beat == rd_q.len);
        if (axi3_rd_if.rready) begin
          rd_d.addr = next_f(rd_q.addr, rd_q.burst, rd_q.len);
          rd_d.beat = rd_q.beat + 4'd1;
          if (r_last) rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    // State still reflects the aborted burst during the reset cycle; mask it.
    if (rst) begin
      ar_rdy = 1'b0;
      r_vld  = 1'b0;
      r_id   = '0;
      r_data = '0;
      r_resp = 2'b00;
      r_last = 1'b0;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_d       = wr_q;
    err_d      = err_q;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    b_vld      = 1'b0;
    b_id       = '0;
    b_resp     = 2'b00;
    mem_we     = 1'b0;
    mem_idx    = idx_f(wr_q.addr);
    unique case (wr_state_q)
      WR_IDLE: begin
        aw_rdy = 1'b1;
        if (axi3_wr_if.awvalid) begin
          wr_d = '{id: axi3_wr_if.awid, addr: axi3_wr_if.awaddr, len: axi3_wr_if.awlen,
                   burst: axi3_wr_if.awburst, size: axi3_wr_if.awsize, beat: 4'd0};
          err_d      = 1'b0;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        w_rdy = 1'b1;
        if (axi3_wr_if.wvalid) begin
          mem_we = !oor_f(wr_q.addr);
          err_d  = err_q || oor_f(wr_q.addr) || (axi3_wr_if.wid != wr_q.id) ||
                   (axi3_wr_if.wlast != (wr_q.beat == wr_q.len)) ||
                   bad_f(wr_q.size, wr_q.burst, wr_q.len);
          wr_d.addr = next_f(wr_q.addr, wr_q.burst, wr_q.len);
          wr_d.beat = wr_q.beat + 4'd1;
          if (wr_q.beat == wr_q.len) wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        b_vld  = 1'b1;
        b_id   = wr_q.id;
        b_resp = err_q ? 2'b10 : 2'b00;
        if (axi3_wr_if.bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (rst) begin
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      b_vld  = 1'b0;
      b_id   = '0;
      b_resp = 2'b00;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      rd_q       <= '0;
      wr_q       <= '0;
      rd_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rd_cnt_q   <= rd_cnt_d;
      err_q      <= err_d;
    end
  end

  // Contents survive reset on purpose: benches reset the fabric, not the memory.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++)
        if (axi3_wr_if.wstrb[i]) mem_q[mem_idx][i] <= axi3_wr_if.wdata[8*i +: 8];
    end
  end

  assign axi3_rd_if.arready = ar_rdy;
  assign axi3_rd_if.rvalid  = r_vld;
  assign axi3_rd_if.rid     = r_id;
  assign axi3_rd_if.rdata   = r_data;
  assign axi3_rd_if.rresp   = r_resp;
  assign axi3_rd_if.rlast   = r_last;
  assign axi3_wr_if.awready = aw_rdy;
  assign axi3_wr_if.wready  = w_rdy;
  assign axi3_wr_if.bvalid  = b_vld;
  assign axi3_wr_if.bid     = b_id;
  assign axi3_wr_if.bresp   = b_resp;
endmodule

// File: doc/axi3_mem_slave.md
Name: axi3_mem_slave

Overview:
- AXI3 responder (slave) backed by an internal word-addressed memory.
- Answers the master side used by the uncached/write-through pass unit and by the caches.
- Serves as the uncached-peripheral / main-memory model in block and system benches.
- Read and write channels are independent.
- Single-beat and INCR/WRAP/FIXED bursts of up to 16 beats are supported; programmable read latency exercises master wait states.

Parameters:
- DATA_WIDTH, 32: data bus width; only 32 supported (4-byte beats).
- MEM_DEPTH, 1024: memory size in 32-bit words; power of two.
- RD_DELAY, 2: cycles from AR handshake to first R beat; 0 allowed.
- BASE_ADDR, 32'h0: byte address mapped to word 0.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- axi3_rd_if  axi3_rd_if.slave  interface  AR/R channels: drives arready, rid, rdata, rresp, rlast, rvalid
- axi3_wr_if  axi3_wr_if.slave  interface  AW/W/B channels: drives awready, wready, bid, bresp, bvalid

Behaviour:
- Reset (sync, active-high): while rst is high, arready, awready, wready, rvalid and bvalid are 0, and rid, rdata, rresp, rlast, bid, bresp are 0.
- Reset: both FSMs go to IDLE and the burst counters clear. Memory contents are not cleared.
- Reset mid-burst aborts the burst; no R or B response is ever issued for it.
- Address map: word index = (addr - BASE_ADDR) >> 2. A beat is out of range (OOR) when the index is >= MEM_DEPTH or addr < BASE_ADDR.
- Read FSM RD_IDLE:
  - arready = 1.
  - On arvalid, latch arid, araddr, arlen, arburst and arsize, and clear the beat count.
  - Go to RD_WAIT if RD_DELAY > 0, else RD_DATA.
- Read FSM RD_WAIT: arready = 0; count RD_DELAY cycles, then go to RD_DATA.
- Read FSM RD_DATA:
  - rvalid = 1, rid = latched arid, rdata = mem[current word] (0 if OOR), rlast = (beat == arlen).
  - All R outputs stay stable while rvalid && !rready.
  - On rready, advance the address and beat count. If rlast, return to RD_IDLE.
  - The next AR is accepted no earlier than the cycle after the last beat.
- Address advance per beat:
  - INCR (2'b01): +4.
  - FIXED (2'b00): unchanged.
  - WRAP (2'b10): +4 within a (arlen+1)*4-byte aligned window, wrapping to the window base.
  - 2'b11: treated as INCR.
- rresp per beat is OKAY (2'b00) except SLVERR (2'b10) in these cases:
  - the beat is OOR;
  - arsize != 3'b010;
  - arburst == 2'b11;
  - WRAP with arlen not in {1,3,7,15}.
- Write FSM WR_IDLE:
  - awready = 1.
  - On awvalid, latch awid, awaddr, awlen and awburst, clear the beat count and the error flag.
  - Go to WR_DATA.
- Write FSM WR_DATA:
  - wready = 1.
  - On wvalid, write each byte lane i where wstrb[i] = 1 into mem[current word]; skip the write if OOR.
  - Advance the address using the same rules as reads.
  - Set the error flag on any of: OOR, wid != latched awid, wlast != (beat == awlen), or illegal size/burst (same rules as reads).
  - On the beat where beat == awlen, go to WR_RESP.
  - The burst length comes from awlen only; wlast is checked but does not terminate the burst.
- Write FSM WR_RESP:
  - bvalid = 1, bid = latched awid, bresp = error flag ? 2'b10 : 2'b00.
  - Stay until bready, then go to WR_IDLE.
- Write timing: the memory write commits at the clock edge of the W handshake. An R beat to the same word in that cycle returns the old data; later beats return the new data.
- Channel independence: read and write bursts may overlap in any phase and never stall each other.
- Outstanding transactions: one read and one write at a time; arready and awready are 0 whenever the respective FSM is not IDLE.
- Latency:
  - Single-beat read: first rvalid RD_DELAY+1 cycles after the AR handshake cycle.
  - Single-beat write: bvalid the cycle after the W handshake.

Test Plan:
- Single write then read (RD_DELAY=2): AW addr 0x10, W 0xDEADBEEF, wstrb 4'hF, wlast=1 -> bvalid next cycle, bresp 0, bid = awid. Then AR 0x10 -> rvalid exactly 3 cycles after the AR handshake, rdata 0xDEADBEEF, rlast=1, rresp 0.
- Byte strobes: write 0x11223344 to 0x20, then 0xAABBCCDD with wstrb 4'b0101 -> read 0x20 returns 0x11BB33DD.
- INCR 4-beat read of 0x40..0x4C with rready toggled 1,0,0,1,1,0,1 -> four beats in order, rdata/rlast held stable while stalled, rlast only on beat 3, arready low until after that beat.
- WRAP 4-beat read from 0x38 -> beats read words 0x38, 0x3C, 0x30, 0x34. FIXED 3-beat write to 0x50 with data 1,2,3 -> mem[0x50] == 3.
- Errors:
  - Read at BASE_ADDR + MEM_DEPTH*4 -> rdata 0, rresp 2'b10.
  - Write with wlast asserted on beat 0 of awlen=1 -> second beat still accepted, bresp 2'b10.
  - Write with wid != awid -> bresp 2'b10.
- Concurrency and reset: a 4-beat write and a 4-beat read to the same word run simultaneously -> both complete, and the read beat coincident with the write handshake returns old data. Asserting rst mid-burst -> all valids/readies 0 that cycle; after deassertion arready = awready = 1 and no stale R/B is issued.
